mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_ctrl.sv | 99 +++++++++
 tb/tb_mul_seq_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-and-add unsigned multiplier controller (IDLE/RUN/DONE).
// Optional macro MUL_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one multiplier bit consumed per edge
// DONE  | product valid, done high for this single cycle
module mul_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_mplier_sh;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_nx;

    // Start is honoured from IDLE and DONE only, so a request during RUN is dropped.
    assign w_accept    = start && (r_state != RUN);
    assign w_mplier_sh = r_mplier >> 1;
    assign w_addend    = r_mplier[0] ? (r_mcand << r_cnt) : '0;
    assign w_acc_nx    = r_acc + w_addend;

`ifdef MUL_EARLY_TERM_EN
    assign w_last = (w_mplier_sh == '0);
`else
    assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nx = RUN;
            RUN:     if (w_last) w_state_nx = DONE;
            DONE:    w_state_nx = start ? RUN : IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == RUN) begin
            r_acc    <= w_acc_nx;
            r_mplier <= w_mplier_sh;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_product <= w_acc_nx;
            end
        end
    end

    assign busy    = (r_state == RUN);
    assign done    = (r_state == DONE);
    assign product = r_product;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl at WIDTH=4; directed scenarios plus random operands.
// Expected products and latencies come from plain arithmetic on the operands.
module tb_mul_seq_ctrl;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int             vectors;
    int             miscompares;
    logic [2*W-1:0] last_p;

    mul_seq_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_lat(input int bv);
`ifdef MUL_EARLY_TERM_EN
        int hi;
        hi = 0;
        for (int i = 0; i < W; i++) if (bv[i]) hi = i + 1;
        return (hi == 0) ? 1 : hi;
`else
        return W;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered at the falling edge k edges after the accepting edge; returns at the done cycle.
    task automatic wait_done(input string tag, input int k0, input int exp_lat, input logic [2*W-1:0] exp_p);
        int k;
        k = k0;
        while (done !== 1'b1 && k <= W + 4) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_hold"}, {24'd0, product}, {24'd0, last_p});
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_lat"}, k, exp_lat);
        chk({tag, "_prod"}, {24'd0, product}, {24'd0, exp_p});
        chk({tag, "_nbusy"}, {31'd0, busy}, 32'd0);
        last_p = exp_p;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv);
        @(negedge clk);
        start = 1'b1; a = ta; b = tbv;
        @(negedge clk);
        start = 1'b0;
        wait_done(tag, 0, model_lat(int'(tbv)), 8'(int'(ta) * int'(tbv)));
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; last_p = '0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_prod", {24'd0, product}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("s3x5", 4'd3, 4'd5);
        run_op("s15x15", 4'd15, 4'd15);
        run_op("s9x0", 4'd9, 4'd0);

        // Second request two cycles into a 7*6 operation must be dropped.
        @(negedge clk);
        start = 1'b1; a = 4'd7; b = 4'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ign_busy", {31'd0, busy}, 32'd1);
        start = 1'b1; a = 4'd1; b = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", 3, model_lat(6), 8'd42);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ign_single", {30'd0, busy, done}, 32'd0);
            chk("ign_keep", {24'd0, product}, 32'd42);
        end

        // Back-to-back: start held, new operands shown in the DONE cycle.
        @(negedge clk);
        start = 1'b1; a = 4'd2; b = 4'd3;
        @(negedge clk);
        wait_done("b2b1", 0, model_lat(3), 8'd6);
        a = 4'd4; b = 4'd4;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_noidle", {31'd0, busy}, 32'd1);
        chk("b2b_nodone", {31'd0, done}, 32'd0);
        wait_done("b2b2", 0, model_lat(4), 8'd16);
        @(negedge clk);

        // Reset in the middle of 13*11.
        @(negedge clk);
        start = 1'b1; a = 4'd13; b = 4'd11;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_prod", {24'd0, product}, 32'd0);
        last_p = '0;
        @(negedge clk);
        chk("rst_ign_start", {30'd0, busy, done}, 32'd0);
        for (int i = 0; i < W + 1; i++) begin
            @(posedge clk);
            #1;
            chk("rst_no_done", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        run_op("s13x11", 4'd13, 4'd11);

        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            run_op("rand", ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
